// File: rtl/vga_box_pattern.sv
// rtl/vga_box_pattern.sv - bouncing-box pixel source for vga_drive
// Registered RGB per pixel: blank outside active area, box over border over background.
module vga_box_pattern #(
  parameter int          H_ACTIVE     = 640,
  parameter int          V_ACTIVE     = 480,
  parameter int          BOX_SIZE     = 32,
  parameter int          STEP         = 2,
  parameter int          FRAME_DIV    = 1,
  parameter logic [23:0] BOX_COLOR    = 24'hFF0000,
  parameter logic [23:0] BG_COLOR     = 24'h0000FF,
  parameter logic [23:0] BORDER_COLOR = 24'hFFFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] addr_h,
  input  logic [11:0] addr_v,
  output logic [23:0] rgb_data,
  output logic        corner_hit
);

  localparam int             FW        = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [FW-1:0]  FCNT_LAST = FW'(FRAME_DIV - 1);
  localparam logic [12:0]    H_LIM     = 13'(H_ACTIVE);
  localparam logic [12:0]    V_LIM     = 13'(V_ACTIVE);
  localparam logic [12:0]    SZ_STEP   = 13'(BOX_SIZE + STEP);
  localparam logic [12:0]    SZ        = 13'(BOX_SIZE);
  localparam logic [11:0]    STEP_W    = 12'(STEP);
  localparam logic [11:0]    X_MAX     = 12'(H_ACTIVE - BOX_SIZE);
  localparam logic [11:0]    Y_MAX     = 12'(V_ACTIVE - BOX_SIZE);

  typedef enum logic [1:0] {DR, DL, UR, UL} dir_t;

  dir_t          dir, dir_nxt;
  logic [11:0]   box_x, box_y, box_x_nxt, box_y_nxt;
  logic [FW-1:0] fcnt, fcnt_nxt;
  logic          colour_sel, colour_sel_nxt;
  logic          fe, fe_d, upd_evt, do_move;
  logic          x_inc, y_inc, x_inc_nxt, y_inc_nxt;
  logic          flip_x, flip_y, hit_nxt;
  logic          in_active, in_box, on_border;
  logic [23:0]   pix_nxt;

  assign fe      = (addr_h == 12'(H_ACTIVE - 1)) && (addr_v == 12'(V_ACTIVE - 1));
  assign upd_evt = fe && !fe_d;
  assign do_move = upd_evt && (fcnt == FCNT_LAST);
  assign x_inc   = (dir == DR) || (dir == UR);
  assign y_inc   = (dir == DR) || (dir == DL);

  always_comb begin
    box_x_nxt      = box_x;
    box_y_nxt      = box_y;
    fcnt_nxt       = fcnt;
    colour_sel_nxt = colour_sel;
    dir_nxt        = dir;
    flip_x         = 1'b0;
    flip_y         = 1'b0;
    x_inc_nxt      = x_inc;
    y_inc_nxt      = y_inc;
    hit_nxt        = 1'b0;
    if (upd_evt)
      fcnt_nxt = do_move ? '0 : fcnt + FW'(1);
    if (do_move) begin
      // 13-bit sums keep the far-edge test free of wrap-around
      if (x_inc) begin
        if ({1'b0, box_x} + SZ_STEP >= H_LIM) begin
          box_x_nxt = X_MAX;
          flip_x    = 1'b1;
        end else begin
          box_x_nxt = box_x + STEP_W;
        end
      end else if (box_x <= STEP_W) begin
        box_x_nxt = '0;
        flip_x    = 1'b1;
      end else begin
        box_x_nxt = box_x - STEP_W;
      end
      if (y_inc) begin
        if ({1'b0, box_y} + SZ_STEP >= V_LIM) begin
          box_y_nxt = Y_MAX;
          flip_y    = 1'b1;
        end else begin
          box_y_nxt = box_y + STEP_W;
        end
      end else if (box_y <= STEP_W) begin
        box_y_nxt = '0;
        flip_y    = 1'b1;
      end else begin
        box_y_nxt = box_y - STEP_W;
      end
      x_inc_nxt = x_inc ^ flip_x;
      y_inc_nxt = y_inc ^ flip_y;
      case ({y_inc_nxt, x_inc_nxt})
        2'b11:   dir_nxt = DR;
        2'b10:   dir_nxt = DL;
        2'b01:   dir_nxt = UR;
        default: dir_nxt = UL;
      endcase
      hit_nxt = flip_x && flip_y;
      if (hit_nxt)
        colour_sel_nxt = ~colour_sel;
    end
  end

  // Pixel colour is resolved against the pre-update box position
  always_comb begin
    in_active = (addr_h < 12'(H_ACTIVE)) && (addr_v < 12'(V_ACTIVE));
    in_box    = (addr_h >= box_x) && ({1'b0, addr_h} < {1'b0, box_x} + SZ) &&
                (addr_v >= box_y) && ({1'b0, addr_v} < {1'b0, box_y} + SZ);
    on_border = (addr_h == 12'd0) || (addr_h == 12'(H_ACTIVE - 1)) ||
                (addr_v == 12'd0) || (addr_v == 12'(V_ACTIVE - 1));
    if (!in_active)
      pix_nxt = 24'h000000;
    else if (in_box)
      pix_nxt = colour_sel ? ~BOX_COLOR : BOX_COLOR;
    else if (on_border)
      pix_nxt = BORDER_COLOR;
    else
      pix_nxt = BG_COLOR;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dir        <= DR;
      box_x      <= '0;
      box_y      <= '0;
      fcnt       <= '0;
      colour_sel <= 1'b0;
      fe_d       <= 1'b0;
      rgb_data   <= '0;
      corner_hit <= 1'b0;
    end else begin
      dir        <= dir_nxt;
      box_x      <= box_x_nxt;
      box_y      <= box_y_nxt;
      fcnt       <= fcnt_nxt;
      colour_sel <= colour_sel_nxt;
      fe_d       <= fe;
      rgb_data   <= pix_nxt;
      corner_hit <= hit_nxt;
    end
  end

endmodule

// File: tb/tb_vga_box_pattern.sv
// tb/tb_vga_box_pattern.sv - randomized bench for vga_box_pattern
// Small 48x48 screen, 8-pixel box, step 3, moves every 2nd frame.
module tb_vga_box_pattern;

  localparam int          H   = 48;
  localparam int          V   = 48;
  localparam int          B   = 8;
  localparam int          S   = 3;
  localparam int          FD  = 2;
  localparam logic [23:0] BOX = 24'hFF0000;
  localparam logic [23:0] BG  = 24'h0000FF;
  localparam logic [23:0] BRD = 24'hFFFFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] addr_h, addr_v;
  logic [23:0] rgb_data;
  logic        corner_hit;

  vga_box_pattern #(
    .H_ACTIVE(H), .V_ACTIVE(V), .BOX_SIZE(B), .STEP(S), .FRAME_DIV(FD),
    .BOX_COLOR(BOX), .BG_COLOR(BG), .BORDER_COLOR(BRD)
  ) dut (
    .clk(clk), .rst(rst), .addr_h(addr_h), .addr_v(addr_v),
    .rgb_data(rgb_data), .corner_hit(corner_hit)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Behavioural model: box position, per-axis velocity sign, frame counter
  int bx, by, dx, dy, fc, n_upd;
  bit csel, pfe;

  logic [23:0] exp_d, exp_rgb;
  logic        hit_d, exp_hit;

  function automatic void model_reset();
    bx = 0; by = 0; dx = 1; dy = 1; fc = 0; csel = 0; pfe = 0;
  endfunction

  function automatic logic [23:0] model_pix(int h, int v);
    if (h >= H || v >= V) return 24'h000000;
    if (h >= bx && h < bx + B && v >= by && v < by + B) return csel ? ~BOX : BOX;
    if (h == 0 || h == H - 1 || v == 0 || v == V - 1) return BRD;
    return BG;
  endfunction

  // Moves one axis; returns 1 when it bounced
  function automatic bit move_axis(inout int p, inout int d, input int lim);
    int np;
    np = p + d * S;
    if (np + B > lim) begin p = lim - B; d = -1; return 1; end
    if (np <= 0) begin p = 0; d = 1; return (d == 1) && (np <= 0); end
    p = np;
    return 0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_rgb <= '0;
      exp_hit <= 1'b0;
    end else begin
      exp_rgb <= exp_d;
      exp_hit <= hit_d;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      n_cmp++;
      if (rgb_data !== exp_rgb) begin
        n_bad++;
        $display("FAIL rgb_model t=%0t: got %h want %h", $time, rgb_data, exp_rgb);
      end
      n_cmp++;
      if (corner_hit !== exp_hit) begin
        n_bad++;
        $display("FAIL hit_model t=%0t: got %b want %b", $time, corner_hit, exp_hit);
      end
    end
  end

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  // Present one pixel address for one clock, advance the model, return at posedge+1
  task automatic drive(input int h, input int v);
    bit fe, fx, fy;
    addr_h = h[11:0];
    addr_v = v[11:0];
    exp_d  = model_pix(h, v);
    hit_d  = 1'b0;
    fe     = (h == H - 1) && (v == V - 1);
    if (fe && !pfe) begin
      if (fc == FD - 1) begin
        fc = 0;
        n_upd++;
        fx = move_axis(bx, dx, H);
        fy = move_axis(by, dy, V);
        if (fx && fy) begin
          hit_d = 1'b1;
          csel  = ~csel;
        end
      end else begin
        fc++;
      end
    end
    pfe = fe;
    @(posedge clk);
    #1;
  endtask

  int hh, vv, hold;

  initial begin
    rst = 1'b0; addr_h = '0; addr_v = '0;
    exp_d = '0; hit_d = 1'b0; n_upd = 0;
    model_reset();
    #1 rst = 1'b1;
    #1 chk_en = 1'b1;
    check("rst_rgb", rgb_data, 24'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    drive(0, 0);   check("px_0_0_box", rgb_data, 24'hFF0000);
    drive(20, 0);  check("px_20_0_border", rgb_data, 24'hFFFFFF);
    drive(20, 20); check("px_20_20_bg", rgb_data, 24'h0000FF);
    drive(50, 10); check("px_50_10_blank", rgb_data, 24'h000000);
    drive(9, 9);   check("px_9_9_bg", rgb_data, 24'h0000FF);

    // Frame end held 5 cycles: one event per frame, movement every 2nd frame
    repeat (5) drive(H - 1, V - 1);
    drive(9, 9);   check("div_frame1_still", rgb_data, 24'h0000FF);
    repeat (5) drive(H - 1, V - 1);
    drive(9, 9);   check("div_frame2_moved", rgb_data, 24'hFF0000);
    drive(2, 2);   check("div_old_corner_bg", rgb_data, 24'h0000FF);

    // 26 more events -> update 14, both axes reach 40 together
    for (int k = 0; k < 25; k++) begin
      drive(H - 1, V - 1);
      drive(1, 1);
    end
    drive(H - 1, V - 1);
    check("corner_hit_pulse", {23'd0, corner_hit}, 24'd1);
    drive(1, 1);
    check("corner_hit_drop", {23'd0, corner_hit}, 24'd0);
    drive(44, 44); check("box_inverted", rgb_data, 24'h00FFFF);
    drive(39, 44); check("box_left_of", rgb_data, 24'h0000FF);

    for (int c = 0; c < 3000; c++) begin
      if (hold == 0) begin
        if ($urandom_range(0, 99) < 30) begin
          hh = H - 1; vv = V - 1;
        end else begin
          hh = $urandom_range(0, 55); vv = $urandom_range(0, 55);
        end
        hold = $urandom_range(1, 4);
      end
      hold--;
      drive(hh, vv);
    end

    // Mid-frame asynchronous reset
    drive(H - 1, V - 1);
    drive(20, 20);
    rst = 1'b1;
    model_reset();
    #1;
    check("async_rst_rgb", rgb_data, 24'h0);
    check("async_rst_hit", {23'd0, corner_hit}, 24'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    drive(0, 0);   check("post_rst_origin", rgb_data, 24'hFF0000);
    drive(9, 9);   check("post_rst_bg", rgb_data, 24'h0000FF);
    repeat (2) begin
      drive(H - 1, V - 1);
      drive(1, 1);
    end
    drive(9, 9);   check("post_rst_dir_dr", rgb_data, 24'hFF0000);

    @(negedge clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_box_pattern.md
Name: vga_box_pattern

Overview:
Pixel-data source feeding vga_drive's rgb_data input, in place of the static data_drive.
- Consumes the pixel coordinates (addr_h/addr_v) produced by vga_drive.
- Returns a 24-bit RGB value per pixel: background, 1-pixel screen border, and a solid square box that bounces around the active area.
- Box position advances once per FRAME_DIV frames, only after the last active pixel, so no tearing occurs.

Parameters:
H_ACTIVE, 640, active pixels per line
V_ACTIVE, 480, active lines per frame
BOX_SIZE, 32, box edge length in pixels (must be < H_ACTIVE, V_ACTIVE)
STEP, 2, pixels moved per update on each axis (1..BOX_SIZE)
FRAME_DIV, 1, frames per position update (>=1)
BOX_COLOR, 24'hFF0000, box colour while colour_sel=0; ~BOX_COLOR while colour_sel=1
BG_COLOR, 24'h0000FF, background colour
BORDER_COLOR, 24'hFFFFFF, edge-pixel colour

Ports:
clk  input  1  pixel clock (vga_clk from vga_drive)
rst  input  1  asynchronous, active-high reset
addr_h  input  12  current pixel column from vga_drive
addr_v  input  12  current pixel row from vga_drive
rgb_data  output  24  registered pixel colour {R,G,B} to vga_drive
corner_hit  output  1  one-cycle pulse when both axes bounce on the same update

Behaviour:
- Reset: one clock; reset asynchronous, active-high.
  - Asserting rst clears all state immediately: box_x=0, box_y=0, dir state DR, fcnt=0, colour_sel=0, fe_d=0, rgb_data=0, corner_hit=0.
  - Reset mid-frame discards motion state; the frame restarts from the origin after release.
- Frame-end detect:
  - fe = (addr_h==H_ACTIVE-1 && addr_v==V_ACTIVE-1); fe_d registers fe.
  - Update event = fe && !fe_d (rising edge). An address held for several cycles gives exactly one event.
- Frame divider: fcnt counts update events 0..FRAME_DIV-1. The position update fires on the event where fcnt==FRAME_DIV-1, then fcnt wraps to 0.
- Direction FSM: states DR, DL, UR, UL (D/U = y increasing/decreasing; R/L = x increasing/decreasing). Per axis, evaluated in parallel on each position update:
  - Increasing: if pos+BOX_SIZE+STEP >= ACTIVE then pos <= ACTIVE-BOX_SIZE and the axis flips to decreasing; else pos <= pos+STEP.
  - Decreasing: if pos <= STEP then pos <= 0 and the axis flips to increasing; else pos <= pos-STEP.
  - Next state = combination of both axis results.
  - Both axes flip on the same update: corner_hit=1 for that one cycle and colour_sel toggles.
- Arithmetic: positions are 12 bits unsigned; comparisons use 13-bit sums so there is no wrap. Position is never outside [0, ACTIVE-BOX_SIZE].
- Pixel colour: registered, 1-cycle latency from addr to rgb_data. Priority order:
  1. addr_h>=H_ACTIVE or addr_v>=V_ACTIVE -> 24'h000000
  2. box_x<=addr_h<box_x+BOX_SIZE and box_y<=addr_v<box_y+BOX_SIZE -> box colour (per colour_sel)
  3. addr_h==0, addr_h==H_ACTIVE-1, addr_v==0 or addr_v==V_ACTIVE-1 -> BORDER_COLOR
  4. otherwise -> BG_COLOR
  - Box overrides border where they overlap.
- Timing of updates: new box position/colour take effect on the cycle after the update event. The pixel evaluated in the same cycle as the event uses the old position.

Test Plan:
1. Reset then a default-parameter frame scan -> rgb_data=0 during rst; after release (1-cycle latency):
   - (0,0) -> FF0000 (box)
   - (40,0) -> FFFFFF
   - (100,100) -> 0000FF
   - (700,10) -> 000000
2. H_ACTIVE=64, V_ACTIVE=48, BOX_SIZE=8, STEP=3, FRAME_DIV=1, 19 frames:
   - box_x sequence 0,3,...,54,56; dir x flips to L at update 19.
   - Further updates: 53,50,...,2,0, then right again.
3. Same params, y axis -> box_y 0,3,...,39,40 at update 14; y flips to U.
4. H_ACTIVE=V_ACTIVE=48, BOX_SIZE=8, STEP=3 -> at update 14 both axes reach 40:
   - corner_hit high exactly 1 cycle; state DR->UL.
   - Box pixels become 00FFFF.
5. FRAME_DIV=2, frame-end address held 5 cycles per frame -> one event per frame; box moves every 2nd frame only (0,0,3,3,6).
6. Assert rst mid-frame with box at (27,27) -> rgb_data=0 immediately (asynchronous); after release the box is at (0,0), state DR, colour BOX_COLOR.
